data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Two-port request/response arbiter and sequencer in front of the byte-lane data memory unit.
- Port 0 is the core load/store path; port 1 is the loader/debug path.
- Accepts one access at a time, drives the memory control signals for exactly one cycle, waits out the BRAM read latency, then returns registered read data (or a write acknowledge) to the winning requester.
- Round-robin arbitration keeps either port from starving the other.

Parameters:
READ_LATENCY, 1, cycles from mem_en high to mem_dout valid (legal range 1..4)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid / req1_valid  input  1  request present on port N
req0_ready / req1_ready  output  1  request accepted this cycle (valid&ready = handshake)
req0_we / req1_we  input  1  1 = store, 0 = load
req0_addr / req1_addr  input  64  byte address
req0_wdata / req1_wdata  input  64  store data, right-aligned
req0_width / req1_width  input  2  00 byte, 01 half, 10 word, 11 double
req0_signed / req1_signed  input  1  sign-extend load result
rsp0_valid / rsp1_valid  output  1  one-cycle response pulse to port N
rsp0_rdata / rsp1_rdata  output  64  load data (0 for stores)
rsp0_err / rsp1_err  output  1  access rejected (see Optional Feature)
mem_en  output  1  memory enable
mem_wea  output  1  memory write enable
mem_addr  output  64  memory address
mem_din  output  64  memory write data
mem_bit_width  output  2  memory access width
mem_sign_extend  output  1  memory sign-extend select
mem_dout  input  64  memory read data

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset enters IDLE.
- Reset values: all outputs 0; last_grant = 1, so port 0 wins the first tie.
- IDLE, winner selection: if only one reqN_valid is high, that port wins. If both are high, the port not in last_grant wins.
- IDLE, handshake: reqN_ready is combinational, high only for the winner and only in IDLE. The other port's ready is 0.
- On handshake: capture we/addr/wdata/width/signed into mem_* registers, record the port, update last_grant, go to ISSUE.
- ISSUE (1 cycle): mem_en=1 and mem_wea=we. Load a latency counter with READ_LATENCY-1, then go to WAIT.
- WAIT: hold while the counter is nonzero, decrementing each cycle. When the counter is 0, capture mem_dout (stores capture 0) into the response register and go to RESP.
- RESP (1 cycle): rspN_valid=1 on the recorded port only, with rspN_rdata. Then return to IDLE.
- Timing: handshake cycle T, mem_en in T+1, rsp_valid in T+2+READ_LATENCY.
- Throughput: one access per READ_LATENCY+3 cycles.
- Outside ISSUE: mem_en=0 and mem_wea=0. mem_addr/din/width/sign_extend hold their last values.
- rspN_rdata holds until the next response to that port. rsp_valid is never high on both ports at once.
- Requesters must hold reqN_valid and fields stable until ready. A valid dropped before ready is ignored without side effects.
- A request arriving during ISSUE/WAIT/RESP sees ready=0 and waits.
- Reset mid-operation: the FSM aborts to IDLE, no response is emitted, and mem_en drops immediately (asynchronous).

Optional Feature:
- Macro: DATA_MEM_ALIGN_CHECK_EN.
- When defined: at handshake, an access with addr[2:0] not a multiple of the width byte count is rejected.
  - Half: addr[0]!=0. Word: addr[1:0]!=0. Double: addr[2:0]!=0.
  - The FSM goes directly to RESP. mem_en stays 0, rspN_err=1, rspN_rdata=0.
  - rspN_err is 0 on all accepted accesses.
- When undefined: misaligned accesses pass through, since the memory unit handles lane rotation. rspN_err is tied 0.

Test Plan:
1. Reset release, port 0 store double 0x1122334455667788 to addr 0x10, then port 0 load double from 0x10 (READ_LATENCY=1) -> mem_en pulses at T+1, rsp0_valid at T+3, rsp0_rdata=0x1122334455667788.
2. Both ports valid every cycle for 8 requests each -> grants alternate 0,1,0,1…, starting with port 0; each port receives exactly 8 responses, in order.
3. Byte 0x80 stored at 0x23, then signed byte load and unsigned byte load from 0x23 -> rdata 0xFFFFFFFFFFFFFF80 and 0x0000000000000080.
4. READ_LATENCY=3, load accepted -> WAIT lasts 3 cycles, rsp_valid exactly 5 cycles after handshake, req ready held 0 throughout.
5. rst_n asserted during WAIT -> all outputs 0 immediately, no rsp_valid after release, next request serviced normally.
6. DATA_MEM_ALIGN_CHECK_EN defined, word load at 0x6 -> no mem_en, rsp_err=1 and rsp_valid one cycle after handshake; undefined -> normal access, rsp_err=0.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// Request/response bundle for one requester of the data memory arbiter.
// The requester side uses the master modport, the arbiter the slave modport.
interface data_mem_arbiter_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_width;
    logic        req_signed;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_width, req_signed,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_width, req_signed,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the byte-lane data
// memory. Port 0 is the core load/store path, port 1 the loader/debug path.
// One access is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP.
// Optional build macro DATA_MEM_ALIGN_CHECK_EN: misaligned accesses are
// rejected at handshake and answered with rsp_err instead of touching memory.
module data_mem_arbiter #(
    parameter int READ_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    data_mem_arbiter_if.slave        port0,
    data_mem_arbiter_if.slave        port1,
    output logic                     mem_en,
    output logic                     mem_wea,
    output logic [63:0]              mem_addr,
    output logic [63:0]              mem_din,
    output logic [1:0]               mem_bit_width,
    output logic                     mem_sign_extend,
    input  logic [63:0]              mem_dout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // Counter preload so that WAIT lasts exactly READ_LATENCY cycles.
    localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY - 1);

    state_t      state;
    state_t      state_next;
    logic        last_grant;
    logic        cur_port;
    logic        cur_we;
    logic [2:0]  lat_cnt;
    logic [63:0] rdata0;
    logic [63:0] rdata1;

    logic        any_valid;
    logic        win_port;
    logic        accept;
    logic        reject;
    logic        sel_we;
    logic [63:0] sel_addr;
    logic [63:0] sel_wdata;
    logic [1:0]  sel_width;
    logic        sel_signed;

`ifdef DATA_MEM_ALIGN_CHECK_EN
    logic        cur_err;

    // An access is misaligned when the low address bits are not a multiple
    // of the access size in bytes.
    function automatic logic misaligned(input logic [1:0] width, input logic [2:0] low);
        case (width)
            2'b01:   return low[0];
            2'b10:   return |low[1:0];
            2'b11:   return |low;
            default: return 1'b0;
        endcase
    endfunction

    assign reject = misaligned(sel_width, sel_addr[2:0]);
`else
    assign reject = 1'b0;
`endif

    // Winner selection: a lone requester wins, a tie goes to the port not granted last.
    always_comb begin
        any_valid = port0.req_valid | port1.req_valid;
        if (port0.req_valid && port1.req_valid) begin
            win_port = ~last_grant;
        end else begin
            win_port = port1.req_valid;
        end
        accept     = (state == IDLE) && any_valid;
        sel_we     = win_port ? port1.req_we     : port0.req_we;
        sel_addr   = win_port ? port1.req_addr   : port0.req_addr;
        sel_wdata  = win_port ? port1.req_wdata  : port0.req_wdata;
        sel_width  = win_port ? port1.req_width  : port0.req_width;
        sel_signed = win_port ? port1.req_signed : port0.req_signed;
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the strobes that are pure functions of the state.
    always_comb begin
        state_next      = state;
        mem_en          = 1'b0;
        mem_wea         = 1'b0;
        port0.req_ready = 1'b0;
        port1.req_ready = 1'b0;
        port0.rsp_valid = 1'b0;
        port1.rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    port0.req_ready = ~win_port;
                    port1.req_ready = win_port;
                    state_next      = reject ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                mem_en     = 1'b1;
                mem_wea    = cur_we;
                state_next = WAIT;
            end
            WAIT: begin
                if (lat_cnt == 3'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                port0.rsp_valid = ~cur_port;
                port1.rsp_valid = cur_port;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Access capture at handshake, latency countdown and response data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant      <= 1'b1;
            cur_port        <= 1'b0;
            cur_we          <= 1'b0;
            lat_cnt         <= 3'd0;
            rdata0          <= 64'd0;
            rdata1          <= 64'd0;
            mem_addr        <= 64'd0;
            mem_din         <= 64'd0;
            mem_bit_width   <= 2'd0;
            mem_sign_extend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cur_port        <= win_port;
                        last_grant      <= win_port;
                        cur_we          <= sel_we;
                        mem_addr        <= sel_addr;
                        mem_din         <= sel_wdata;
                        mem_bit_width   <= sel_width;
                        mem_sign_extend <= sel_signed;
                        // A rejected access answers with zero data straight away.
                        if (reject) begin
                            if (win_port) rdata1 <= 64'd0;
                            else          rdata0 <= 64'd0;
                        end
                    end
                end
                ISSUE: begin
                    lat_cnt <= LAT_INIT;
                end
                WAIT: begin
                    if (lat_cnt != 3'd0) begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end else if (cur_port) begin
                        rdata1 <= cur_we ? 64'd0 : mem_dout;
                    end else begin
                        rdata0 <= cur_we ? 64'd0 : mem_dout;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DATA_MEM_ALIGN_CHECK_EN
    // Remember whether the access in flight was rejected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_err <= 1'b0;
        end else if (accept) begin
            cur_err <= reject;
        end
    end

    assign port0.rsp_err = port0.rsp_valid & cur_err;
    assign port1.rsp_err = port1.rsp_valid & cur_err;
`else
    assign port0.rsp_err = 1'b0;
    assign port1.rsp_err = 1'b0;
`endif

    assign port0.rsp_rdata = rdata0;
    assign port1.rsp_rdata = rdata1;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: one instance with READ_LATENCY=1 and
// one with READ_LATENCY=3, each in front of a small byte-lane memory model.
module tb_data_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    data_mem_arbiter_if pa0 ();
    data_mem_arbiter_if pa1 ();
    data_mem_arbiter_if pb0 ();
    data_mem_arbiter_if pb1 ();

    logic        en_a, wea_a, se_a, en_b, wea_b, se_b;
    logic [63:0] addr_a, din_a, dout_a, addr_b, din_b, dout_b;
    logic [1:0]  w_a, w_b;

    data_mem_arbiter #(.READ_LATENCY(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .port0(pa0), .port1(pa1),
        .mem_en(en_a), .mem_wea(wea_a), .mem_addr(addr_a), .mem_din(din_a),
        .mem_bit_width(w_a), .mem_sign_extend(se_a), .mem_dout(dout_a)
    );

    data_mem_arbiter #(.READ_LATENCY(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .port0(pb0), .port1(pb1),
        .mem_en(en_b), .mem_wea(wea_b), .mem_addr(addr_b), .mem_din(din_b),
        .mem_bit_width(w_b), .mem_sign_extend(se_b), .mem_dout(dout_b)
    );

    logic [7:0]  mem [256];
    logic [63:0] pipe_b [3];

    function automatic logic [63:0] mem_rd(input logic [63:0] a, input logic [1:0] w, input logic s);
        logic [63:0] v;
        int n;
        v = 64'd0;
        n = 1 << w;
        for (int i = 0; i < 8; i++) if (i < n) v[8*i +: 8] = mem[a[7:0] + 8'(i)];
        if (s && v[8*n-1]) for (int i = 0; i < 8; i++) if (i >= n) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    // Shared memory array; reads of dut A return after 1 cycle, dut B after 3.
    always @(posedge clk) begin
        if (en_a && wea_a) for (int i = 0; i < 8; i++) if (i < (1 << w_a)) mem[addr_a[7:0] + 8'(i)] <= din_a[8*i +: 8];
        if (en_b && wea_b) for (int i = 0; i < 8; i++) if (i < (1 << w_b)) mem[addr_b[7:0] + 8'(i)] <= din_b[8*i +: 8];
        dout_a    <= (en_a && !wea_a) ? mem_rd(addr_a, w_a, se_a) : 64'd0;
        pipe_b[0] <= (en_b && !wea_b) ? mem_rd(addr_b, w_b, se_b) : 64'd0;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign dout_b = pipe_b[2];

    task automatic drive(input int d, input int p, input logic we, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [1:0] width, input logic sgn);
        if (d == 0 && p == 0) begin
            pa0.req_we = we; pa0.req_addr = addr; pa0.req_wdata = wdata;
            pa0.req_width = width; pa0.req_signed = sgn; pa0.req_valid = 1'b1;
        end else if (d == 0) begin
            pa1.req_we = we; pa1.req_addr = addr; pa1.req_wdata = wdata;
            pa1.req_width = width; pa1.req_signed = sgn; pa1.req_valid = 1'b1;
        end else if (p == 0) begin
            pb0.req_we = we; pb0.req_addr = addr; pb0.req_wdata = wdata;
            pb0.req_width = width; pb0.req_signed = sgn; pb0.req_valid = 1'b1;
        end else begin
            pb1.req_we = we; pb1.req_addr = addr; pb1.req_wdata = wdata;
            pb1.req_width = width; pb1.req_signed = sgn; pb1.req_valid = 1'b1;
        end
    endtask

    task automatic clear_valid();
        pa0.req_valid = 1'b0; pa1.req_valid = 1'b0;
        pb0.req_valid = 1'b0; pb1.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        clear_valid();
        for (int p = 0; p < 2; p++) for (int d = 0; d < 2; d++) drive(d, p, 1'b0, 64'd0, 64'd0, 2'd0, 1'b0);
        clear_valid();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if ({en_a, wea_a, en_b, wea_b} !== 4'b0) begin bad++; $display("FAIL rst_mem_en: got %b want 0000", {en_a, wea_a, en_b, wea_b}); end
        total++; if (addr_a !== 64'd0 || din_a !== 64'd0) begin bad++; $display("FAIL rst_mem_addr: got %h/%h want 0", addr_a, din_a); end
        total++; if ({pa0.req_ready, pa1.req_ready, pa0.rsp_valid, pa1.rsp_valid} !== 4'b0) begin bad++; $display("FAIL rst_hs: got %b want 0000", {pa0.req_ready, pa1.req_ready, pa0.rsp_valid, pa1.rsp_valid}); end
        total++; if (pa0.rsp_rdata !== 64'd0 || pa0.rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp: got %h/%b want 0", pa0.rsp_rdata, pa0.rsp_err); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        int i0 = 0, i1 = 0, r0 = 0, r1 = 0, cyc = 0;
        logic exp_port = 1'b0;
        logic got;
        while ((r0 < 8 || r1 < 8) && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (pa0.rsp_valid) begin
                total++; if (pa0.rsp_rdata !== 64'd0 || pa1.rsp_valid !== 1'b0) begin bad++; $display("FAIL rr_rsp0: got %h/%b want 0/0", pa0.rsp_rdata, pa1.rsp_valid); end
                r0++;
            end
            if (pa1.rsp_valid) begin
                total++; if (pa1.rsp_rdata !== 64'hC0DE_0000_0000_0000 + 64'(r1)) begin bad++; $display("FAIL rr_rsp1: got %h want %h", pa1.rsp_rdata, 64'hC0DE_0000_0000_0000 + 64'(r1)); end
                r1++;
            end
            if (i0 < 8) drive(0, 0, 1'b1, 64'h40 + 64'(8 * i0), 64'hC0DE_0000_0000_0000 + 64'(i0), 2'd3, 1'b0);
            else pa0.req_valid = 1'b0;
            if (i1 < 8) drive(0, 1, 1'b0, 64'h40 + 64'(8 * i1), 64'd0, 2'd3, 1'b0);
            else pa1.req_valid = 1'b0;
            #1;
            if (pa0.req_ready || pa1.req_ready) begin
                got = pa1.req_ready;
                total++; if ((pa0.req_ready && pa1.req_ready) || got !== exp_port) begin bad++; $display("FAIL rr_grant: got %b%b want port %0d", pa1.req_ready, pa0.req_ready, exp_port); end
                if (pa0.req_ready) i0++; else i1++;
                exp_port = ~exp_port;
            end
        end
        clear_valid();
        total++; if (r0 != 8 || r1 != 8) begin bad++; $display("FAIL rr_count: got %0d/%0d want 8/8", r0, r1); end
    endtask

    task automatic test_store_load();
        @(negedge clk);
        drive(0, 0, 1'b1, 64'h10, 64'h1122334455667788, 2'd3, 1'b0);
        #1;
        total++; if ({pa1.req_ready, pa0.req_ready} !== 2'b01) begin bad++; $display("FAIL sl_ready: got %b want 01", {pa1.req_ready, pa0.req_ready}); end
        @(negedge clk);
        clear_valid();
        total++; if ({en_a, wea_a} !== 2'b11 || addr_a !== 64'h10 || din_a !== 64'h1122334455667788 || w_a !== 2'd3) begin bad++; $display("FAIL sl_issue: got %b %h %h %0d want 11 10 1122334455667788 3", {en_a, wea_a}, addr_a, din_a, w_a); end
        @(negedge clk);
        total++; if ({en_a, pa0.rsp_valid} !== 2'b00) begin bad++; $display("FAIL sl_wait: got %b want 00", {en_a, pa0.rsp_valid}); end
        @(negedge clk);
        total++; if (pa0.rsp_valid !== 1'b1 || pa0.rsp_rdata !== 64'd0 || pa0.rsp_err !== 1'b0) begin bad++; $display("FAIL sl_store_rsp: got %b %h %b want 1 0 0", pa0.rsp_valid, pa0.rsp_rdata, pa0.rsp_err); end
        @(negedge clk);
        drive(0, 0, 1'b0, 64'h10, 64'd0, 2'd3, 1'b0);
        #1;
        total++; if (pa0.req_ready !== 1'b1 || pa0.rsp_valid !== 1'b0) begin bad++; $display("FAIL sl_load_hs: got %b/%b want 1/0", pa0.req_ready, pa0.rsp_valid); end
        @(negedge clk);
        clear_valid();
        total++; if ({en_a, wea_a} !== 2'b10) begin bad++; $display("FAIL sl_load_issue: got %b want 10", {en_a, wea_a}); end
        @(negedge clk);
        total++; if (pa0.rsp_valid !== 1'b0) begin bad++; $display("FAIL sl_load_early: got %b want 0", pa0.rsp_valid); end
        @(negedge clk);
        total++; if (pa0.rsp_valid !== 1'b1 || pa0.rsp_rdata !== 64'h1122334455667788) begin bad++; $display("FAIL sl_load_rsp: got %b %h want 1 1122334455667788", pa0.rsp_valid, pa0.rsp_rdata); end
    endtask

    task automatic test_sign_extend();
        logic        we_t  [3] = '{1'b1, 1'b0, 1'b0};
        logic        sgn_t [3] = '{1'b0, 1'b1, 1'b0};
        logic [63:0] exp_t [3] = '{64'd0, 64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_0080};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(0, 0, we_t[k], 64'h23, 64'hAAAA_AAAA_AAAA_AA80, 2'd0, sgn_t[k]);
            #1;
            total++; if (pa0.req_ready !== 1'b1) begin bad++; $display("FAIL se_ready%0d: got %b want 1", k, pa0.req_ready); end
            @(negedge clk);
            clear_valid();
            total++; if (en_a !== 1'b1 || se_a !== sgn_t[k] || w_a !== 2'd0) begin bad++; $display("FAIL se_issue%0d: got %b %b %0d want 1 %b 0", k, en_a, se_a, w_a, sgn_t[k]); end
            @(negedge clk);
            @(negedge clk);
            total++; if (pa0.rsp_valid !== 1'b1 || pa0.rsp_rdata !== exp_t[k]) begin bad++; $display("FAIL se_rsp%0d: got %b %h want 1 %h", k, pa0.rsp_valid, pa0.rsp_rdata, exp_t[k]); end
        end
    endtask

    task automatic test_latency3();
        @(negedge clk);
        drive(1, 1, 1'b1, 64'h80, 64'hDEAD_BEEF_CAFE_F00D, 2'd3, 1'b0);
        #1;
        total++; if (pb1.req_ready !== 1'b1) begin bad++; $display("FAIL l3_store_ready: got %b want 1", pb1.req_ready); end
        @(negedge clk);
        clear_valid();
        repeat (5) @(negedge clk);
        drive(1, 0, 1'b0, 64'h80, 64'd0, 2'd3, 1'b0);
        drive(1, 1, 1'b0, 64'h84, 64'd0, 2'd2, 1'b0);
        #1;
        total++; if ({pb1.req_ready, pb0.req_ready} !== 2'b01) begin bad++; $display("FAIL l3_tie: got %b want 01", {pb1.req_ready, pb0.req_ready}); end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            pb0.req_valid = 1'b0;
            total++; if (pb1.req_ready !== 1'b0 || en_b !== (k == 1) || pb0.rsp_valid !== (k == 5)) begin bad++; $display("FAIL l3_cycle%0d: got rdy=%b en=%b rsp=%b", k, pb1.req_ready, en_b, pb0.rsp_valid); end
        end
        total++; if (pb0.rsp_rdata !== 64'hDEAD_BEEF_CAFE_F00D) begin bad++; $display("FAIL l3_rdata: got %h want deadbeefcafef00d", pb0.rsp_rdata); end
        @(negedge clk);
        total++; if (pb1.req_ready !== 1'b1) begin bad++; $display("FAIL l3_p1_ready: got %b want 1", pb1.req_ready); end
        @(negedge clk);
        clear_valid();
        repeat (3) @(negedge clk);
        @(negedge clk);
        total++; if (pb1.rsp_valid !== 1'b1 || pb1.rsp_rdata !== 64'h0000_0000_DEAD_BEEF) begin bad++; $display("FAIL l3_p1_rsp: got %b %h want 1 00000000deadbeef", pb1.rsp_valid, pb1.rsp_rdata); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        @(negedge clk);
        drive(0, 0, 1'b0, 64'h10, 64'd0, 2'd3, 1'b0);
        @(negedge clk);
        clear_valid();
        drive(1, 0, 1'b0, 64'h80, 64'd0, 2'd3, 1'b0);
        @(negedge clk);
        clear_valid();
        total++; if (en_b !== 1'b1) begin bad++; $display("FAIL rm_pre_en: got %b want 1", en_b); end
        rst_n = 1'b0;
        #1;
        total++; if ({en_a, en_b, wea_b} !== 3'b000) begin bad++; $display("FAIL rm_en_drop: got %b want 000", {en_a, en_b, wea_b}); end
        total++; if (pa0.rsp_rdata !== 64'd0 || pb0.rsp_rdata !== 64'd0 || addr_a !== 64'd0 || addr_b !== 64'd0) begin bad++; $display("FAIL rm_clear: got %h %h %h %h want 0", pa0.rsp_rdata, pb0.rsp_rdata, addr_a, addr_b); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (pa0.rsp_valid || pa1.rsp_valid || pb0.rsp_valid || pb1.rsp_valid || en_a || en_b) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL rm_silent: got %0d active cycles want 0", seen); end
        drive(0, 0, 1'b0, 64'h10, 64'd0, 2'd3, 1'b0);
        #1;
        total++; if (pa0.req_ready !== 1'b1) begin bad++; $display("FAIL rm_after_ready: got %b want 1", pa0.req_ready); end
        @(negedge clk);
        clear_valid();
        repeat (2) @(negedge clk);
        total++; if (pa0.rsp_valid !== 1'b1 || pa0.rsp_rdata !== 64'h1122334455667788) begin bad++; $display("FAIL rm_after_rsp: got %b %h want 1 1122334455667788", pa0.rsp_valid, pa0.rsp_rdata); end
    endtask

    task automatic test_align();
        @(negedge clk);
        drive(0, 1, 1'b0, 64'h12, 64'd0, 2'd2, 1'b0);
        #1;
        total++; if (pa1.req_ready !== 1'b1) begin bad++; $display("FAIL al_ready: got %b want 1", pa1.req_ready); end
        @(negedge clk);
        clear_valid();
`ifdef DATA_MEM_ALIGN_CHECK_EN
        total++; if (en_a !== 1'b0 || pa1.rsp_valid !== 1'b1 || pa1.rsp_err !== 1'b1 || pa1.rsp_rdata !== 64'd0) begin bad++; $display("FAIL al_reject: got en=%b v=%b err=%b %h want 0 1 1 0", en_a, pa1.rsp_valid, pa1.rsp_err, pa1.rsp_rdata); end
        @(negedge clk);
        total++; if (pa1.rsp_valid !== 1'b0 || pa1.rsp_err !== 1'b0) begin bad++; $display("FAIL al_reject_end: got %b/%b want 0/0", pa1.rsp_valid, pa1.rsp_err); end
        drive(0, 1, 1'b0, 64'h14, 64'd0, 2'd2, 1'b0);
        @(negedge clk);
        clear_valid();
        total++; if (en_a !== 1'b1) begin bad++; $display("FAIL al_ok_issue: got %b want 1", en_a); end
        repeat (2) @(negedge clk);
        total++; if (pa1.rsp_valid !== 1'b1 || pa1.rsp_err !== 1'b0 || pa1.rsp_rdata !== 64'h11223344) begin bad++; $display("FAIL al_ok_rsp: got %b %b %h want 1 0 11223344", pa1.rsp_valid, pa1.rsp_err, pa1.rsp_rdata); end
`else
        total++; if (en_a !== 1'b1) begin bad++; $display("FAIL al_pass_issue: got %b want 1", en_a); end
        repeat (2) @(negedge clk);
        total++; if (pa1.rsp_valid !== 1'b1 || pa1.rsp_err !== 1'b0 || pa1.rsp_rdata !== 64'h33445566) begin bad++; $display("FAIL al_pass_rsp: got %b %b %h want 1 0 33445566", pa1.rsp_valid, pa1.rsp_err, pa1.rsp_rdata); end
`endif
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_store_load();
        test_sign_extend();
        test_latency3();
        test_reset_mid();
        test_align();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
